// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave slice.
//   spi_slave_state_t   : frame-tracking states of the responder
//   SPI_SYNC_STAGES     : depth of the pin synchronizers
//   SPI_MAXLEN_DEFAULT  : word length shared with the SPI master
package spi_pkg;

    localparam int SPI_MAXLEN_DEFAULT = 16;
    localparam int SPI_SYNC_STAGES    = 2;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } spi_slave_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: the SPI pins plus the local TX/RX handshake.
//   sclk, cs_n, mosi   : SPI pins from the master (async to clk)
//   miso               : SPI data back to the master
//   tx_data/valid/ready: one-entry response buffer handshake
//   rx_data/valid      : received word and its one-cycle strobe
//   tx_underrun        : word started with no response queued
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int SPI_MAXLEN = SPI_MAXLEN_DEFAULT
);
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic [SPI_MAXLEN-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [SPI_MAXLEN-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, tx_ready, rx_data, rx_valid, tx_underrun
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, tx_ready, rx_data, rx_valid, tx_underrun
    );
endinterface

// File: rtl/spi_sync.sv
// Single-bit N-stage synchronizer with a configurable reset value.
//   clk, rst : system clock, async active-high reset
//   d        : asynchronous input
//   q        : synchronized output (STAGES clk of latency)
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= {STAGES{RST_VAL}};
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder running entirely on the system clock.
//   clk, rst : system clock, async active-high reset
//   bus      : spi_slave_if.slave (SPI pins, TX buffer handshake, RX strobe)
// Received words are presented as single-cycle rx_valid pulses; response
// words are taken from a one-entry buffer at every word start.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_MAXLEN = SPI_MAXLEN_DEFAULT
) (
    input logic        clk,
    input logic        rst,
    spi_slave_if.slave bus
);
    localparam int CNT_W = $clog2(SPI_MAXLEN) + 1;

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_q, cs_q;
    logic rise, fall, cs_fall, cs_rise;
    logic [SPI_SYNC_STAGES:0] flush_q;

    spi_slave_state_t      state_q, state_d;
    logic [SPI_MAXLEN-2:0] shin_q, shin_d;
    logic [SPI_MAXLEN-1:0] shout_q, shout_d;
    logic [SPI_MAXLEN-1:0] buf_q, buf_d;
    logic [SPI_MAXLEN-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic arm_q, arm_d, full_q, full_d;
    logic rx_valid_q, rx_valid_d, underrun_q, underrun_d;
    logic load;

    spi_sync #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(bus.sclk), .q(sclk_s));
    spi_sync #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(bus.cs_n), .q(cs_n_s));
    spi_sync #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(bus.mosi), .q(mosi_s));

    assign rise    =  sclk_s & ~sclk_q;
    assign fall    = ~sclk_s &  sclk_q;
    assign cs_fall = ~cs_n_s &  cs_q;
    assign cs_rise =  cs_n_s & ~cs_q;

    // --- state and datapath registers ---
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            flush_q    <= '0;
            state_q    <= WAIT_IDLE;
            shin_q     <= '0;
            shout_q    <= '0;
            buf_q      <= '0;
            rx_data_q  <= '0;
            cnt_q      <= '0;
            arm_q      <= 1'b0;
            full_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            sclk_q     <= sclk_s;
            cs_q       <= cs_n_s;
            flush_q    <= {flush_q[SPI_SYNC_STAGES-1:0], 1'b1};
            state_q    <= state_d;
            shin_q     <= shin_d;
            shout_q    <= shout_d;
            buf_q      <= buf_d;
            rx_data_q  <= rx_data_d;
            cnt_q      <= cnt_d;
            arm_q      <= arm_d;
            full_q     <= full_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
        end
    end

    // --- next-state, shifting and TX buffer logic ---
    always_comb begin
        state_d    = state_q;
        shin_d     = shin_q;
        shout_d    = shout_q;
        buf_d      = buf_q;
        rx_data_d  = rx_data_q;
        cnt_d      = cnt_q;
        arm_d      = arm_q;
        full_d     = full_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;

        unique case (state_q)
            WAIT_IDLE: begin
                // The synchronizers reset cs_n to 1, so a high reading is only
                // trusted once the real pin level has flushed through them and
                // the edge register; otherwise a frame in progress at reset
                // would look like a fresh cs_fall.
                if (flush_q[SPI_SYNC_STAGES] && cs_n_s) state_d = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    arm_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    // A partial word is dropped; cs_rise also beats a same-cycle rise.
                    cnt_d   = '0;
                    arm_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (rise) begin
                        shin_d = {shin_q[SPI_MAXLEN-3:0], mosi_s};
                        if (cnt_q == CNT_W'(SPI_MAXLEN - 1)) begin
                            rx_data_d  = {shin_q, mosi_s};
                            rx_valid_d = 1'b1;
                            cnt_d      = '0;
                            arm_d      = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    if (fall) begin
                        if (arm_q) begin
                            load  = 1'b1;
                            arm_d = 1'b0;
                        end else begin
                            shout_d = {shout_q[SPI_MAXLEN-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase

        if (load) begin
            if (full_q) begin
                shout_d = buf_q;
                full_d  = 1'b0;
            end else begin
                shout_d    = '0;
                underrun_d = 1'b1;
            end
        end

        // Handshake only happens while empty, so data accepted in a load
        // cycle is kept for the following word.
        if (bus.tx_valid && !full_q) begin
            buf_d  = bus.tx_data;
            full_d = 1'b1;
        end
    end

    assign bus.miso        = (state_q == SHIFT) ? shout_q[SPI_MAXLEN-1] : 1'b0;
    assign bus.tx_ready    = ~full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed and randomized bench for spi_slave: a bit-level SPI master drives
// the pins, a monitor logs rx_valid words and tx_underrun pulses, and each
// frame is compared against the words the master sent and the words queued.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int W = 16;

    logic clk;
    logic rst;

    spi_slave_if #(.SPI_MAXLEN(W)) bus ();

    spi_slave #(.SPI_MAXLEN(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int rx_cnt   = 0;
    int uf_cnt   = 0;
    int uf_mark  = 0;
    logic [W-1:0] rx_log   [64];
    logic [W-1:0] send_w   [4];
    logic [W-1:0] got_miso [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            if (rx_cnt < 64) rx_log[rx_cnt] = bus.rx_data;
            rx_cnt++;
        end
        if (bus.tx_underrun) uf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_push(input logic [W-1:0] d);
        int n = 0;
        while (!bus.tx_ready && n < 200) begin
            tick(1);
            n++;
        end
        check("tx_ready_wait", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic cs_low(input int hp);
        bus.cs_n = 1'b0;
        bus.mosi = send_w[0][W-1];
        tick(hp);
    endtask

    task automatic cs_high(input int hp);
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        tick(hp + 4);
    endtask

    // Mode 0: sample miso just before raising sclk, change mosi after the fall.
    task automatic bits(input int start, input int n, input int hp);
        for (int b = start; b < start + n; b++) begin
            got_miso[b / W][W - 1 - (b % W)] = bus.miso;
            bus.sclk = 1'b1;
            tick(hp);
            uf_mark  = uf_cnt;
            bus.sclk = 1'b0;
            if ((b + 1) / W < 4) bus.mosi = send_w[(b + 1) / W][W - 1 - ((b + 1) % W)];
            else                 bus.mosi = 1'b0;
            tick(hp);
        end
    endtask

    initial begin
        int rx0, uf0, hp;
        logic [W-1:0] wrd, txw;
        logic pre;
        logic [W-1:0] exp_rx_q[$];
        logic [W-1:0] exp_tx_q[$];

        rst          = 1'b1;
        bus.sclk     = 1'b0;
        bus.cs_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        tick(3);

        check("rst_miso",        32'(bus.miso),        32'd0);
        check("rst_tx_ready",    32'(bus.tx_ready),    32'd1);
        check("rst_rx_data",     32'(bus.rx_data),     32'd0);
        check("rst_rx_valid",    32'(bus.rx_valid),    32'd0);
        check("rst_tx_underrun", 32'(bus.tx_underrun), 32'd0);
        rst = 1'b0;
        tick(6);

        // Basic word
        tx_push(16'hA5C3);
        check("basic_tx_full", 32'(bus.tx_ready), 32'd0);
        rx0 = rx_cnt; uf0 = uf_cnt;
        send_w[0] = 16'h1234;
        cs_low(4); bits(0, 16, 4); cs_high(4);
        check("basic_rx_count", 32'(rx_cnt - rx0), 32'd1);
        check("basic_rx_word",  32'(rx_log[rx0]),  32'h1234);
        check("basic_miso",     32'(got_miso[0]),  32'hA5C3);
        check("basic_no_uf",    32'(uf_mark - uf0), 32'd0);
        check("basic_tx_ready", 32'(bus.tx_ready), 32'd1);

        // Two words in one frame, buffer refilled during the first word
        tx_push(16'hC0DE);
        rx0 = rx_cnt; uf0 = uf_cnt;
        send_w[0] = 16'hBEEF; send_w[1] = 16'h0001;
        fork
            begin cs_low(4); bits(0, 32, 4); cs_high(4); end
            begin tick(14); tx_push(16'h0F0F); end
        join
        check("two_rx_count", 32'(rx_cnt - rx0),    32'd2);
        check("two_rx_word0", 32'(rx_log[rx0]),     32'hBEEF);
        check("two_rx_word1", 32'(rx_log[rx0 + 1]), 32'h0001);
        check("two_miso0",    32'(got_miso[0]),     32'hC0DE);
        check("two_miso1",    32'(got_miso[1]),     32'h0F0F);
        check("two_no_uf",    32'(uf_mark - uf0),   32'd0);

        // Underrun
        rx0 = rx_cnt; uf0 = uf_cnt;
        send_w[0] = 16'hFFFF;
        cs_low(4); bits(0, 16, 4); cs_high(4);
        check("uf_pulses",   32'(uf_mark - uf0), 32'd1);
        check("uf_miso",     32'(got_miso[0]),   32'h0000);
        check("uf_rx_count", 32'(rx_cnt - rx0),  32'd1);
        check("uf_rx_data",  32'(bus.rx_data),   32'hFFFF);

        // Abort after 9 bits, then a full frame
        rx0 = rx_cnt;
        send_w[0] = 16'($urandom);
        cs_low(5); bits(0, 9, 5); cs_high(5);
        check("abort_no_rx",   32'(rx_cnt - rx0), 32'd0);
        check("abort_rx_hold", 32'(bus.rx_data),  32'hFFFF);
        wrd = 16'($urandom);
        send_w[0] = wrd;
        cs_low(5); bits(0, 16, 5); cs_high(5);
        check("abort_next_count", 32'(rx_cnt - rx0), 32'd1);
        check("abort_next_word",  32'(rx_log[rx0]),  32'(wrd));

        // Reset in the middle of a frame
        send_w[0] = 16'($urandom);
        cs_low(4);
        tx_push(16'h1111);
        check("mid_tx_full", 32'(bus.tx_ready), 32'd0);
        bits(0, 5, 4);
        rst = 1'b1;
        #2;
        check("mid_rst_miso",     32'(bus.miso),        32'd0);
        check("mid_rst_tx_ready", 32'(bus.tx_ready),    32'd1);
        check("mid_rst_rx_data",  32'(bus.rx_data),     32'd0);
        check("mid_rst_rx_valid", 32'(bus.rx_valid),    32'd0);
        check("mid_rst_uf",       32'(bus.tx_underrun), 32'd0);
        #1;
        rst = 1'b0;
        tick(1);
        rx0 = rx_cnt;
        bits(5, 11, 4);
        check("mid_ignored", 32'(rx_cnt - rx0), 32'd0);
        check("mid_rx_zero", 32'(bus.rx_data),  32'd0);
        cs_high(4);
        wrd = 16'($urandom);
        send_w[0] = wrd;
        cs_low(4); bits(0, 16, 4); cs_high(4);
        check("mid_next_count", 32'(rx_cnt - rx0), 32'd1);
        check("mid_next_word",  32'(rx_log[rx0]),  32'(wrd));

        // cs_n rises together with the 16th sclk rise
        rx0 = rx_cnt;
        send_w[0] = 16'($urandom);
        cs_low(4); bits(0, 15, 4);
        bus.sclk = 1'b1;
        bus.cs_n = 1'b1;
        tick(4);
        bus.sclk = 1'b0;
        tick(8);
        check("simul_no_rx", 32'(rx_cnt - rx0), 32'd0);

        // Randomized single-word frames against a queue model
        for (int it = 0; it < 6; it++) begin
            wrd = 16'($urandom);
            txw = 16'($urandom);
            pre = 1'($urandom_range(0, 1));
            hp  = $urandom_range(4, 7);
            exp_rx_q.push_back(wrd);
            exp_tx_q.push_back(pre ? txw : 16'h0000);
            if (pre) tx_push(txw);
            rx0 = rx_cnt; uf0 = uf_cnt;
            send_w[0] = wrd;
            cs_low(hp); bits(0, 16, hp); cs_high(hp);
            check("rand_rx_word", 32'(rx_cnt > rx0 ? rx_log[rx0] : ~wrd), 32'(exp_rx_q.pop_front()));
            check("rand_miso",    32'(got_miso[0]),   32'(exp_tx_q.pop_front()));
            check("rand_uf",      32'(uf_mark - uf0), pre ? 32'd0 : 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
# spi_slave

Mode-0 SPI responder for the SPI master's bus: it receives words framed by `cs_n` and clocked by `sclk` from the master's clock generator, and it returns a response word on `miso` in the same frame. All pins are asynchronous to `clk`, so the block synchronizes them and runs entirely on the system clock. It presents received words to local logic as single-cycle pulses and accepts response words through a one-entry valid/ready buffer.

## Interface
- `SPI_MAXLEN`, 16: word length in bits, shared with the master; MSB first.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `sclk` in 1: SPI clock from the master; idles low (CPOL=0).
- `cs_n` in 1: active-low frame select.
- `mosi` in 1: master-to-slave data.
- `miso` out 1: slave-to-master data. Driven 0 while deselected; the top level handles tri-state.
- `tx_data` in SPI_MAXLEN: response word.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: the TX buffer is empty.
- `rx_data` out SPI_MAXLEN: last complete received word.
- `rx_valid` out 1: one-cycle pulse for each complete word.
- `tx_underrun` out 1: one-cycle pulse when a word starts with the TX buffer empty.

## Operation
- **Synchronization:**
  - `sclk`, `cs_n` and `mosi` each pass through a 2-flop synchronizer with equal depth, so data stays aligned to edges.
  - Synchronizer reset values: `sclk`=0, `cs_n`=1, `mosi`=0.
- **Edge detection:**
  - One extra register per synchronized `sclk` and `cs_n`.
  - `rise` = sclk_s & ~sclk_q; `fall` = ~sclk_s & sclk_q; `cs_fall` and `cs_rise` are formed the same way.
- **States:**
  - WAIT_IDLE (the reset state): waits for synchronized `cs_n`=1, then goes to IDLE. This prevents joining a frame already in progress.
  - IDLE:
    - On `cs_fall`: load the shift-out register (see TX buffer below) and clear `bit_cnt` (width $clog2(SPI_MAXLEN)+1).
    - `miso` then shows the MSB of that register. Go to SHIFT.
  - SHIFT:
    - On `rise`: shift the synchronized `mosi` into the LSB of the shift-in register and increment `bit_cnt`.
    - When the increment reaches SPI_MAXLEN: `rx_data` ← the full word including the new bit; `rx_valid`=1 for one cycle; `bit_cnt`←0; arm a reload.
    - On `fall`: if a reload is armed, load the next word and present its MSB; otherwise shift out left and present the next bit. Multiple words per frame are supported.
    - On `cs_rise`: discard any partial word with no `rx_valid`, then go to IDLE. If `cs_rise` and `rise` occur in the same cycle, `cs_rise` wins and the bit is dropped.
- **TX buffer:**
  - One entry. `tx_ready` = ~full.
  - A cycle with `tx_valid & tx_ready` fills the buffer.
  - On each word load: if the buffer is full, the shift-out register takes the buffer and the buffer empties. If it is empty, the shift-out register takes all zeros and `tx_underrun` pulses.
  - If a load and a handshake fall in the same cycle, the handshake data fills the now-empty buffer for the next word. It is not used for the current word.
- **RX path:** no backpressure. `rx_data` holds its value until the next completed word.

## Timing
- **Reset values:** `miso`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, state WAIT_IDLE.
- **Pin-to-detect latency:** a pin edge is seen as `rise`, `fall` or `cs_fall` 2–3 clk after the pin changes.
- **RX latency:** `rx_valid` asserts 1 clk after the `rise` cycle of the last bit.
- **MISO latency:** `miso` updates 1 clk after `fall` or `cs_fall` is detected, i.e. ≤4 clk after the pin edge.
- **Bus constraints:**
  - `sclk` high and low phases are each ≥4 clk.
  - `cs_n` falling edge to first `sclk` rise is ≥4 clk.
  - Last `sclk` fall to `cs_n` rise is ≥4 clk.
  - The master's clock divider must be configured to meet these.
- **Reset mid-frame:** outputs go to their reset values immediately. The rest of the frame is ignored until `cs_n` is seen high.

## Structure
- **Package `spi_pkg`:**
  - `spi_slave_state_t` enum {WAIT_IDLE, IDLE, SHIFT}.
  - Constant `SPI_SYNC_STAGES`=2.
  - `SPI_MAXLEN` default shared with the master.
- **Sub-module `spi_sync`:** a single-bit N-stage synchronizer with a parameterized reset value, instantiated three times.

## Test plan
- **Basic word:** reset, `tx_data`=16'hA5C3 loaded, master sends 16'h1234 with half-period 4 clk → `rx_data`=16'h1234 with exactly one `rx_valid`; `miso` bits sampled on `sclk` rises = 16'hA5C3; `tx_ready` returns to 1.
- **Two words, one frame:** buffer refilled with 16'h0F0F during the first word; master sends 16'hBEEF then 16'h0001 → two `rx_valid` pulses in order; second `miso` word = 16'h0F0F.
- **Underrun:** no TX load, master sends 16'hFFFF → `tx_underrun` pulses once at `cs_fall`; `miso` is all 0; `rx_data`=16'hFFFF.
- **Abort:** `cs_n` rises after 9 bits → no `rx_valid`, `rx_data` unchanged, state returns to IDLE; the next full frame is received correctly.
- **Reset mid-frame:** `rst` pulsed after 5 bits with `cs_n` still low → outputs at reset values; remaining bits ignored; the next frame after `cs_n` goes high then low is received correctly.
- **Simultaneous events:** `cs_n` rises in the same synchronized cycle as the 16th `sclk` rise → no `rx_valid`.
